// File: rtl/inst_fetch_pkg.sv
// ISA definitions shared by the NECPU front-end: opcodes, field positions, bus widths.
package inst_fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_SET   = 4'd3,
    OP_LT    = 4'd4,
    OP_EQ    = 4'd5,
    OP_BEQ   = 4'd6,
    OP_BNE   = 4'd7,
    OP_ADD   = 4'd8,
    OP_SUB   = 4'd9,
    OP_SHL   = 4'd10,
    OP_SHR   = 4'd11,
    OP_AND   = 4'd12,
    OP_OR    = 4'd13,
    OP_INV   = 4'd14,
    OP_XOR   = 4'd15
  } opcode_t;

  typedef enum logic {
    RUN        = 1'b0,
    WAIT_REDIR = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_classify.sv
// Flags instructions that may write R[0] (the PC) and therefore need a redirect.
module inst_classify
  import inst_fetch_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] rd,
  output logic       is_ctrl
);

  always_comb begin
    is_ctrl = 1'b0;
    case (opcode_t'(op))
      OP_BEQ, OP_BNE:   is_ctrl = 1'b1;
      OP_NOP, OP_STORE: is_ctrl = 1'b0;
      default:          is_ctrl = (rd == 4'd0);
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch/decode front-end: PC-driven fetch, field split, valid/ready issue to execute,
// stall on PC-writing instructions until execute supplies the resolved target.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [3:0]        dec_op,
  output logic [3:0]        dec_rd,
  output logic [3:0]        dec_rs1,
  output logic [3:0]        dec_rs2,
  output logic [7:0]        dec_imm,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic              redir_err
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              is_ctrl;
  logic              fire;
  logic              capture;
  logic              unused_inst_hi;

  // Upper half of the word carries no ISA fields.
  assign unused_inst_hi = ^imem_inst[INST_W-1:16];

  assign imem_addr = pc;
  assign fire      = dec_valid && dec_ready;
  assign capture   = (state == RUN) && (!dec_valid || dec_ready);

  inst_classify u_classify (
    .op      (imem_inst[OP_MSB:OP_LSB]),
    .rd      (imem_inst[RD_MSB:RD_LSB]),
    .is_ctrl (is_ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      dec_valid  <= 1'b0;
      dec_pc     <= '0;
      dec_op     <= '0;
      dec_rd     <= '0;
      dec_rs1    <= '0;
      dec_rs2    <= '0;
      dec_imm    <= '0;
      issued_cnt <= '0;
      redir_err  <= 1'b0;
    end else begin
      if (fire) begin
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (redir_valid) begin
            redir_err <= 1'b1;
          end
          if (capture) begin
            dec_valid <= 1'b1;
            dec_pc    <= pc;
            dec_op    <= imem_inst[OP_MSB:OP_LSB];
            dec_rd    <= imem_inst[RD_MSB:RD_LSB];
            dec_rs1   <= imem_inst[RS1_MSB:RS1_LSB];
            dec_rs2   <= imem_inst[RS2_MSB:RS2_LSB];
            dec_imm   <= imem_inst[IMM_MSB:IMM_LSB];
            if (is_ctrl) begin
              state <= WAIT_REDIR;
            end else begin
              pc <= pc + 32'd1;
            end
          end else if (fire) begin
            dec_valid <= 1'b0;
          end
        end
        WAIT_REDIR: begin
          // The instruction still pending on dec_* is delivered independently of the redirect.
          if (fire) begin
            dec_valid <= 1'b0;
          end
          if (redir_valid) begin
            pc    <= redir_pc;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: straight-line fetch, branch, jump, spurious redirect, async reset, backpressure.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [3:0]  dec_op;
  logic [3:0]  dec_rd;
  logic [3:0]  dec_rs1;
  logic [3:0]  dec_rs2;
  logic [7:0]  dec_imm;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [15:0] issued_cnt;
  logic        redir_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:15];

  assign imem_inst = (imem_addr < 32'd16) ? mem[imem_addr[3:0]] : 32'h0;

  inst_fetch #(.RESET_PC(32'd0), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_op      (dec_op),
    .dec_rd      (dec_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_imm     (dec_imm),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .issued_cnt  (issued_cnt),
    .redir_err   (redir_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] pc, input logic [3:0] op,
                         input logic [3:0] rd, input logic [7:0] imm);
    chk({tag, " valid"}, {31'd0, dec_valid}, 32'd1);
    chk({tag, " pc"},    dec_pc, pc);
    chk({tag, " op"},    {28'd0, dec_op}, {28'd0, op});
    chk({tag, " rd"},    {28'd0, dec_rd}, {28'd0, rd});
    chk({tag, " imm"},   {24'd0, dec_imm}, {24'd0, imm});
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // {op, rd, rs1, rs2}; upper half deliberately dirty in word 0
    mem[0]  = 32'hDEAD_3201;  // SET   R2,1
    mem[1]  = 32'h0000_3180;  // SET   R1,128
    mem[2]  = 32'h0000_8223;  // ADD   R2,R2,R3
    mem[3]  = 32'h0000_2210;  // STORE R2,R1,0
    mem[4]  = 32'h0000_3104;  // SET   R1,4
    mem[5]  = 32'h0000_0000;  // NOP
    mem[6]  = 32'h0000_7400;  // BNE   R4,0
    mem[7]  = 32'h0000_3004;  // SET   R0,4
    mem[8]  = 32'h0000_8555;  // ADD   R5,R5,R5
    mem[9]  = 32'h0000_6000;  // BEQ   R0,0
    for (int i = 10; i < 16; i++) mem[i] = 32'h0;

    rst = 1'b1; dec_ready = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst valid", {31'd0, dec_valid}, 32'd0);
    chk("rst addr", imem_addr, 32'd0);
    chk("rst cnt", {16'd0, issued_cnt}, 32'd0);
    chk("rst err", {31'd0, redir_err}, 32'd0);
    chk("rst fields", {12'd0, dec_op, dec_rd, dec_rs1, dec_rs2}, 32'd0);
    chk("rst pc", dec_pc, 32'd0);
    rst = 1'b0;

    // straight-line fetch, one per cycle
    step; chk_dec("s0", 32'd0, 4'd3, 4'd2, 8'h01); chk("s0 addr", imem_addr, 32'd1);
    step; chk_dec("s1", 32'd1, 4'd3, 4'd1, 8'h80);
    step; chk_dec("s2", 32'd2, 4'd8, 4'd2, 8'h23);
    chk("s2 rs1rs2", {24'd0, dec_rs1, dec_rs2}, 32'h23);
    step; chk_dec("s3", 32'd3, 4'd2, 4'd2, 8'h10); chk("s3 cnt", {16'd0, issued_cnt}, 32'd3);
    step; chk_dec("s4", 32'd4, 4'd3, 4'd1, 8'h04); chk("s4 cnt", {16'd0, issued_cnt}, 32'd4);
    step; chk_dec("s5", 32'd5, 4'd0, 4'd0, 8'h00);

    // BNE at 6: stalls, target 8 returned one cycle after it is consumed
    step; chk_dec("bne", 32'd6, 4'd7, 4'd4, 8'h00); chk("bne addr", imem_addr, 32'd6);
    step; chk("gap1 valid", {31'd0, dec_valid}, 32'd0); chk("gap1 addr", imem_addr, 32'd6);
    chk("gap1 cnt", {16'd0, issued_cnt}, 32'd7);
    redir_valid = 1'b1; redir_pc = 32'd8;
    step; redir_valid = 1'b0;
    chk("gap2 valid", {31'd0, dec_valid}, 32'd0); chk("gap2 addr", imem_addr, 32'd8);
    step; chk_dec("tgt8", 32'd8, 4'd8, 4'd5, 8'h55);
    chk("err after legal redir", {31'd0, redir_err}, 32'd0);

    // BEQ at 9, redirect to 7 while BEQ still presented
    step; chk_dec("beq", 32'd9, 4'd6, 4'd0, 8'h00);
    redir_valid = 1'b1; redir_pc = 32'd7;
    step; redir_valid = 1'b0;
    chk("beq gap valid", {31'd0, dec_valid}, 32'd0); chk("redir7 addr", imem_addr, 32'd7);
    chk("beq cnt", {16'd0, issued_cnt}, 32'd9);

    // SET R0,4 is a jump: stalls until redirect
    step; chk_dec("setr0", 32'd7, 4'd3, 4'd0, 8'h04);
    step; chk("jw1 valid", {31'd0, dec_valid}, 32'd0); chk("jw1 addr", imem_addr, 32'd7);
    step; chk("jw2 valid", {31'd0, dec_valid}, 32'd0); chk("jw2 addr", imem_addr, 32'd7);
    redir_valid = 1'b1; redir_pc = 32'd4;
    step; redir_valid = 1'b0; chk("jmp addr", imem_addr, 32'd4);
    step; chk_dec("j4", 32'd4, 4'd3, 4'd1, 8'h04);
    step; chk_dec("j5 nostall", 32'd5, 4'd0, 4'd0, 8'h00);
    chk("j5 cnt", {16'd0, issued_cnt}, 32'd11);

    // spurious redirect in RUN; BNE at 6 captured on the same edge
    redir_valid = 1'b1; redir_pc = 32'h55;
    step; redir_valid = 1'b0; redir_pc = 32'h0;
    chk("spur err", {31'd0, redir_err}, 32'd1);
    chk_dec("spur bne", 32'd6, 4'd7, 4'd4, 8'h00);
    chk("spur addr", imem_addr, 32'd6);
    dec_ready = 1'b0;
    step; chk("err sticky", {31'd0, redir_err}, 32'd1);
    chk("hold valid", {31'd0, dec_valid}, 32'd1); chk("hold cnt", {16'd0, issued_cnt}, 32'd12);

    // async reset mid-cycle during WAIT_REDIR
    #2 rst = 1'b1;
    #1;
    chk("arst valid", {31'd0, dec_valid}, 32'd0);
    chk("arst addr", imem_addr, 32'd0);
    chk("arst cnt", {16'd0, issued_cnt}, 32'd0);
    chk("arst err", {31'd0, redir_err}, 32'd0);
    @(negedge clk); rst = 1'b0; dec_ready = 1'b1;
    step; chk_dec("after rst", 32'd0, 4'd3, 4'd2, 8'h01);

    // backpressure on addr 1 for 3 cycles
    step; chk_dec("bp0", 32'd1, 4'd3, 4'd1, 8'h80);
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk_dec("bp hold", 32'd1, 4'd3, 4'd1, 8'h80);
      chk("bp addr", imem_addr, 32'd2);
      chk("bp cnt", {16'd0, issued_cnt}, 32'd1);
    end
    dec_ready = 1'b1;
    step; chk_dec("bp2", 32'd2, 4'd8, 4'd2, 8'h23); chk("bp2 cnt", {16'd0, issued_cnt}, 32'd2);
    step; chk_dec("bp3", 32'd3, 4'd2, 4'd2, 8'h10); chk("bp3 cnt", {16'd0, issued_cnt}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
